// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the memory arbiter.
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, RD_IF, RD_D} arb_state_t;
   localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of consecutive lost fetch cycles.
module arb_starve_counter
   import cpu_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic limit_o
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   logic [CW-1:0] cnt_q, cnt_d;
   assign limit_o = cnt_q == LIM;
   always_comb cnt_d = clr_i ? '0 : (inc_i && !limit_o) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between fetch and data ports,
// data wins unless fetch has starved; read data is routed back one cycle later.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_AW       = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_stall,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_be,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   arb_state_t state_q, state_d;
   logic       starved, if_rvalid_q, d_rvalid_q, unused;
   logic [MEM_AW-1:0] if_waddr, d_waddr;
   assign unused   = ^{if_addr, d_addr};
   assign if_waddr = if_addr[MEM_AW+1:2];
   assign d_waddr  = d_addr[MEM_AW+1:2];
   // Grants are gated by reset so the port stays quiet while rst is low.
   assign if_gnt   = rst & if_req & (~d_req | starved);
   assign d_gnt    = rst & d_req & ~(if_req & starved);
   assign if_stall = if_req & ~if_gnt;
   assign mem_en    = if_gnt | d_gnt;
   assign mem_we    = d_gnt & d_we;
   assign mem_addr  = if_gnt ? if_waddr : d_gnt ? d_waddr : '0;
   assign mem_wdata = d_gnt ? d_wdata : '0;
   assign mem_be    = if_gnt ? BE_FULL : d_gnt ? (d_we ? d_be : BE_FULL) : 4'h0;
   arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (if_req & ~if_gnt),
      .clr_i  (~if_req | if_gnt),
      .limit_o(starved)
   );
   always_comb state_d = if_gnt ? RD_IF : (d_gnt & ~d_we) ? RD_D : IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= IDLE;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         if_rvalid_q <= state_d == RD_IF;
         d_rvalid_q  <= state_d == RD_D;
      end
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = (state_q == RD_IF) ? mem_rdata : '0;
   assign d_rdata   = (state_q == RD_D) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner cases and random traffic
// checked against a behavioural arbiter/memory model.
module tb_mem_arbiter;
   localparam int LIM = 4;
   logic        clk = 0, rst = 0;
   logic        if_req = 0, d_req = 0, d_we = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0]  d_be = 0;
   logic        if_gnt, if_stall, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_wdata;
   logic [31:0] mem_rdata = 0;
   logic [9:0]  mem_addr;
   logic [3:0]  mem_be;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] tb_mem [1024];
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= tb_mem[mem_addr];
         end
      end

   int checks = 0, failures = 0;
   int starve = 0, own = 0;
   logic [31:0] exp_rd = 0;
   logic [31:0] ref_mem [1024];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic int widx(logic [31:0] a);
      return int'((a / 4) % 1024);
   endfunction

   task automatic drive(bit ir, logic [31:0] ia, bit dr, bit dwe, logic [31:0] da,
                        logic [31:0] dwd, logic [3:0] dbe);
      if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
   endtask

   // Called at a negedge with inputs applied; checks, advances the model one clock.
   task automatic cycle();
      bit ig, dg;
      logic [31:0] w;
      #1;
      ig = if_req && (!d_req || starve == LIM);
      dg = d_req && !ig;
      chk("if_gnt", if_gnt, ig);
      chk("d_gnt", d_gnt, dg);
      chk("if_stall", if_stall, if_req && !ig);
      chk("mem_en", mem_en, ig || dg);
      chk("mem_we", mem_we, dg && d_we);
      if (ig || dg) begin
         chk("mem_addr", mem_addr, widx(ig ? if_addr : d_addr));
         chk("mem_be", mem_be, (dg && d_we) ? d_be : 4'hF);
      end
      if (dg && d_we) chk("mem_wdata", mem_wdata, d_wdata);
      chk("if_rvalid", if_rvalid, own == 1);
      chk("if_rdata", if_rdata, own == 1 ? exp_rd : 32'h0);
      chk("d_rvalid", d_rvalid, own == 2);
      chk("d_rdata", d_rdata, own == 2 ? exp_rd : 32'h0);
      @(posedge clk);
      starve = (if_req && !ig) ? (starve < LIM ? starve + 1 : LIM) : 0;
      own = ig ? 1 : (dg && !d_we) ? 2 : 0;
      if (own != 0) exp_rd = ref_mem[widx(ig ? if_addr : d_addr)];
      else if (dg) begin
         w = ref_mem[widx(d_addr)];
         for (int b = 0; b < 4; b++) if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
         ref_mem[widx(d_addr)] = w;
      end
      @(negedge clk);
   endtask

   typedef struct {
      bit ir; logic [31:0] ia; bit dr, dwe; logic [31:0] da, dwd; logic [3:0] dbe;
      bit eig, edg; logic [9:0] ema; bit ewe; logic [3:0] ebe;
      bit eiv; logic [31:0] eird; bit edv; logic [31:0] edrd;
   } vec_t;
   vec_t tv[13];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         tb_mem[i]  = 32'h1000_0000 | i;
         ref_mem[i] = 32'h1000_0000 | i;
      end
      tb_mem[0] = 32'h11;   ref_mem[0] = 32'h11;
      tb_mem[1] = 32'h22;   ref_mem[1] = 32'h22;
      tb_mem[2] = 32'h33;   ref_mem[2] = 32'h33;
      tb_mem[16] = 32'hDEAD; ref_mem[16] = 32'hDEAD;
      //         ir ia        dr we da      dwd           be    ig dg ma we be    iv ird          dv drd
      tv[0]  = '{1, 32'h00,   0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 0, 0, 4'hF, 0, 32'h0,        0, 32'h0};
      tv[1]  = '{1, 32'h04,   0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 1, 0, 4'hF, 1, 32'h11,       0, 32'h0};
      tv[2]  = '{1, 32'h08,   0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 2, 0, 4'hF, 1, 32'h22,       0, 32'h0};
      tv[3]  = '{1, 32'h0C,   1, 0, 32'h40, 32'h0,        4'h0, 0, 1, 16, 0, 4'hF, 1, 32'h33,      0, 32'h0};
      tv[4]  = '{0, 32'h0,    1, 1, 32'h08, 32'h12345678, 4'hF, 0, 1, 2, 1, 4'hF, 0, 32'h0,        1, 32'hDEAD};
      tv[5]  = '{0, 32'h0,    1, 1, 32'h08, 32'hAABBCCDD, 4'h3, 0, 1, 2, 1, 4'h3, 0, 32'h0,        0, 32'h0};
      tv[6]  = '{0, 32'h0,    1, 0, 32'h08, 32'h0,        4'h0, 0, 1, 2, 0, 4'hF, 0, 32'h0,        0, 32'h0};
      tv[7]  = '{1, 32'h10,   0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 4, 0, 4'hF, 0, 32'h0,        1, 32'h1234CCDD};
      tv[8]  = '{0, 32'h0,    1, 0, 32'h40, 32'h0,        4'h0, 0, 1, 16, 0, 4'hF, 1, 32'h10000004, 0, 32'h0};
      tv[9]  = '{1, 32'h1003, 0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 0, 0, 4'hF, 0, 32'h0,        1, 32'hDEAD};
      tv[10] = '{1, 32'h08,   1, 1, 32'h08, 32'h55,       4'hF, 0, 1, 2, 1, 4'hF, 1, 32'h11,       0, 32'h0};
      tv[11] = '{1, 32'h08,   0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 2, 0, 4'hF, 0, 32'h0,        0, 32'h0};
      tv[12] = '{0, 32'h0,    0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 32'h55,       0, 32'h0};

      drive(1, 32'h4, 1, 1, 32'h8, 32'hFFFF_FFFF, 4'hF);
      #12;
      chk("rst.if_gnt", if_gnt, 0);
      chk("rst.d_gnt", d_gnt, 0);
      chk("rst.mem_en", mem_en, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_be", mem_be, 0);
      chk("rst.if_rvalid", if_rvalid, 0);
      chk("rst.d_rvalid", d_rvalid, 0);
      chk("rst.if_rdata", if_rdata, 0);
      chk("rst.d_rdata", d_rdata, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1;

      foreach (tv[i]) begin
         drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dwe, tv[i].da, tv[i].dwd, tv[i].dbe);
         #1;
         chk($sformatf("tv%0d.if_gnt", i), if_gnt, tv[i].eig);
         chk($sformatf("tv%0d.d_gnt", i), d_gnt, tv[i].edg);
         chk($sformatf("tv%0d.mem_addr", i), mem_addr, tv[i].ema);
         chk($sformatf("tv%0d.mem_we", i), mem_we, tv[i].ewe);
         chk($sformatf("tv%0d.mem_be", i), mem_be, tv[i].ebe);
         chk($sformatf("tv%0d.if_rvalid", i), if_rvalid, tv[i].eiv);
         chk($sformatf("tv%0d.if_rdata", i), if_rdata, tv[i].eird);
         chk($sformatf("tv%0d.d_rvalid", i), d_rvalid, tv[i].edv);
         chk($sformatf("tv%0d.d_rdata", i), d_rdata, tv[i].edrd);
         cycle();
      end

      // Starvation: fetch loses four cycles, then wins exactly one.
      for (int c = 0; c < 10; c++) begin
         drive(1, 32'h20, 1, 0, 32'h44, 0, 0);
         #1;
         chk($sformatf("starve%0d.if_gnt", c), if_gnt, (c % 5) == 4);
         chk($sformatf("starve%0d.d_gnt", c), d_gnt, (c % 5) != 4);
         cycle();
      end

      // Asynchronous reset while a load is in flight.
      drive(0, 0, 1, 0, 32'h40, 0, 0);
      cycle();
      #1;
      chk("arst.pre_d_rvalid", d_rvalid, 1);
      chk("arst.pre_mem_en", mem_en, 1);
      #1 rst = 0;
      #1;
      chk("arst.d_rvalid", d_rvalid, 0);
      chk("arst.d_rdata", d_rdata, 0);
      chk("arst.mem_en", mem_en, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1;
      starve = 0;
      own = 0;
      @(posedge clk);
      #1;
      chk("arst.post_if_rvalid", if_rvalid, 0);
      chk("arst.post_d_rvalid", d_rvalid, 0);
      @(negedge clk);

      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_F0FF,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom & 32'hFFFF_F0FF, $urandom, 4'($urandom));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory between two requesters: instruction fetch (IF) and data load/store (D).
- Arbitrates each cycle and drives the memory port. Routes the 1-cycle-latency read data back to the requester that issued the read.
- Produces the stall signal for the PC register so fetch holds while the data port owns memory.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requesters
- DATA_WIDTH, 32, word width (must be 32; byte enables are 4 bits)
- MEM_AW, 10, memory word-address width; mem_addr = addr[MEM_AW+1:2]
- STARVE_LIMIT, 4, consecutive lost IF cycles after which IF wins priority

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_stall  out  1  if_req & ~if_gnt; freezes PC
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  MEM_AW  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset (rst low, async):
  - state=IDLE, starve_cnt=0.
  - All outputs 0: gnt, rvalid, mem_en, mem_we, mem_be; rdata outputs 0.
- Grant is combinational, same cycle as req. At most one of if_gnt and d_gnt is high per cycle.
- Priority:
  - D wins by default.
  - IF wins if starve_cnt == STARVE_LIMIT.
  - The sole requester always wins.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when if_req & ~if_gnt.
  - Clears to 0 on if_gnt or when ~if_req.
- Memory port:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_be = d_we ? d_be : 4'hF.
  - mem_addr and mem_wdata come from the granted requester.
  - With no grant, mem_en=0 and the other mem outputs are don't-care (drive 0).
- Response FSM (registered owner of the in-flight read):
  - IDLE: no read in flight.
  - RD_IF: fetch read issued last cycle; if_rvalid=1 and if_rdata=mem_rdata this cycle.
  - RD_D: load issued last cycle; d_rvalid=1 and d_rdata=mem_rdata this cycle.
  - Next state depends only on this cycle's grant: if_gnt→RD_IF; d_gnt & ~d_we→RD_D; otherwise→IDLE.
  - Any state can transition to any state, so back-to-back reads are fully pipelined with 1 read per cycle.
- Read latency is exactly 1 cycle from gnt to rvalid. Stores have no rvalid; d_gnt is their completion.
- Requesters hold req/addr/data stable until gnt; the arbiter does not latch requests.
- Address bits [1:0] are ignored. Bits above MEM_AW+1 are ignored (wrap-around aliasing).
- Simultaneous store by D and read by IF at the same address: D wins (absent starvation). IF reads the new value on its later grant.
- Reset mid-operation: an in-flight read is dropped and no rvalid is produced after reset release.
- if_rdata and d_rdata are 0 when the corresponding rvalid is 0.

Decomposition:
- Shared package (cpu_pkg):
  - typedef enum logic [1:0] {IDLE, RD_IF, RD_D} arb_state_t
  - localparam BE_FULL = 4'hF
- One sub-module, arb_starve_counter: a saturating counter with inc, clr and limit-reached output, parameterised by STARVE_LIMIT. The rest stays flat.

Test Plan:
- Fetch-only stream:
  - Stimulus: if_req=1 with if_addr 0x00, 0x04, 0x08; memory preloaded 0x11,0x22,0x33.
  - Required: if_gnt every cycle; mem_addr 0,1,2; if_rvalid on cycles 1..3 with if_rdata 0x11,0x22,0x33.
- Conflict with data priority:
  - Stimulus: if_req=1 and d_req=1 (load, d_addr=0x40, mem[16]=0xDEAD) in the same cycle.
  - Required: d_gnt=1, if_stall=1, mem_addr=16; next cycle d_rvalid=1, d_rdata=0xDEAD, if_rvalid=0.
- Starvation:
  - Stimulus: d_req held high for 10 cycles with if_req high, STARVE_LIMIT=4.
  - Required: IF loses cycles 0–3 and wins cycle 4 (d_gnt=0 that cycle); starve_cnt then returns to 0.
- Store with byte enables:
  - Stimulus: d_we=1, d_addr=0x08, d_wdata=0xAABBCCDD, d_be=4'b0011, mem[2]=0x12345678 initially.
  - Required: mem_we=1, mem_be=0011, no d_rvalid; a later load of 0x08 returns 0x1234CCDD.
- Back-to-back mixed reads:
  - Stimulus: cycle 0 IF granted, cycle 1 D load granted.
  - Required: cycle 1 if_rvalid=1; cycle 2 d_rvalid=1; both rvalids are never high together.
- Async reset mid-read:
  - Stimulus: assert rst low between clock edges during RD_D.
  - Required: d_rvalid and mem_en go to 0 immediately; no rvalid appears in the first cycle after release.
